sram_arbiter: RTL
=================

// Module: sram_arbiter
// PURPOSE
//   Round-robin arbiter sharing one contiguous_sram between N_CLIENTS requesters
//   (delay lines, loopers, etc.). Clients issue single-word read/write requests
//   over a req/ack handshake; the arbiter serialises them onto the sram's
//   read/write + ready handshake. It returns read data and an error flag per
//   transaction, and has a watchdog against a stalled memory.
// PARAMETERS
//   N_CLIENTS  4   number of requesters (>=2)
//   DATA_W     16  word width, equals sram data_width
//   ADDR_W     13  word address width, equals sram addr_width
//   TIMEOUT    15  max cycles in ISSUE+WAIT before abort (>=4)
// PORTS
//   clk           in   1                  clock
//   reset         in   1                  async active-high reset
//   cl_req        in   N_CLIENTS          per-client request, held until ack
//   cl_we         in   N_CLIENTS          1=write, 0=read
//   cl_addr       in   N_CLIENTS*ADDR_W   packed, client i at [i*ADDR_W +: ADDR_W]
//   cl_wdata      in   N_CLIENTS*DATA_W   packed write data
//   cl_ack        out  N_CLIENTS          1-cycle completion pulse, granted client only
//   cl_rdata      out  DATA_W             read data, valid while cl_ack high
//   cl_err        out  1                  invalid address or timeout, valid with cl_ack
//   mem_read      out  1                  sram read strobe (1 cycle)
//   mem_write     out  1                  sram write strobe (1 cycle)
//   mem_read_addr out  ADDR_W             held stable from ISSUE through ACK
//   mem_write_addr out ADDR_W             held stable from ISSUE through ACK
//   mem_data_in   out  DATA_W             held stable from ISSUE through ACK
//   mem_data_out  in   DATA_W             sram read data
//   mem_read_ready  in 1                  sram read ready
//   mem_write_ready in 1                  sram write ready
//   mem_invalid_read  in 1                sram out-of-range read flag
//   mem_invalid_write in 1                sram out-of-range write flag
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (async): state=IDLE, rr_ptr=0, cl_ack=0, cl_rdata=0, cl_err=0,
//     mem_read/mem_write=0, addrs/data=0, timer=0, err_latch=0. A reset asserted
//     mid-transaction drops it; no ack is issued.
//   - FSM IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
//   - IDLE: if any cl_req is set, grant g = first set bit searching from rr_ptr
//     upward with wrap. Latch cl_we[g], the address (to both mem addr ports) and
//     the data; clear timer and err_latch; go to ISSUE.
//   - ISSUE: once the selected ready (write->mem_write_ready, read->mem_read_ready)
//     is high, pulse the matching strobe for exactly 1 cycle and go to WAIT.
//     Otherwise stay in ISSUE and increment the timer.
//   - WAIT: increment the timer. OR mem_invalid_* into err_latch. When the selected
//     ready is high: capture mem_data_out into cl_rdata (reads only) and go to ACK.
//     WAIT is entered the cycle after the strobe, where ready is already low.
//   - Timeout: if timer reaches TIMEOUT in ISSUE or WAIT, set err_latch, go to ACK,
//     and leave cl_rdata unchanged.
//   - ACK: for 1 cycle, drive cl_ack[g]=1 and cl_err=err_latch; rr_ptr=(g+1) mod
//     N_CLIENTS; return to IDLE. cl_ack and cl_err are 0 in every other state.
//   - Writes leave cl_rdata unchanged.
//   - Fixed read latency, sampled req to ack: IDLE(c0) ISSUE/strobe(c1)
//     WAIT(c2, ready low) WAIT(c3, ready high, capture) ACK(c4).
//     Writes follow the same timing.
//   - The IDLE cycle after ACK covers the sram's post-ready recovery cycle, so
//     back-to-back transactions need no extra stall.
//   - Deasserting cl_req after grant does not cancel: the transaction completes
//     and is acked. Clients must not change we/addr/wdata while req is high.
//   - At most one transaction in flight; mem_read and mem_write are never high
//     together.
// TESTING
//   - Single read: client1 reads addr 0x010 (preloaded 0xBEEF) -> cl_ack[1] at
//     c4, cl_rdata=0xBEEF, cl_err=0, mem_read high exactly 1 cycle.
//   - Write then read: client0 writes 0x1234 to 0x1FFF, then reads 0x1FFF
//     -> rdata 0x1234, both acks clean.
//   - Fairness: all 4 req held continuously from rr_ptr=0 -> ack order 0,1,2,3,0,
//     each ack 5 cycles apart.
//   - Out of range: N_BANKS*BANK_SIZE below 2^ADDR_W, read at the max address
//     -> cl_ack with cl_err=1.
//   - Timeout: mem_read_ready tied low after the strobe -> ack with cl_err=1 after
//     TIMEOUT cycles, then the FSM returns to IDLE and serves the next request.
//   - Reset mid-WAIT -> all outputs 0 the same cycle, no ack; the next request
//     is granted from client 0.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Client request/ack bus and sram-side handshake shared by sram_arbiter.
// slave: the arbiter's view; master: the clients plus sram that surround it.
interface sram_arbiter_if #(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 13
);
    logic [N_CLIENTS-1:0]        cl_req;
    logic [N_CLIENTS-1:0]        cl_we;
    logic [N_CLIENTS*ADDR_W-1:0] cl_addr;
    logic [N_CLIENTS*DATA_W-1:0] cl_wdata;
    logic [N_CLIENTS-1:0]        cl_ack;
    logic [DATA_W-1:0]           cl_rdata;
    logic                        cl_err;

    logic                        mem_read;
    logic                        mem_write;
    logic [ADDR_W-1:0]           mem_read_addr;
    logic [ADDR_W-1:0]           mem_write_addr;
    logic [DATA_W-1:0]           mem_data_in;
    logic [DATA_W-1:0]           mem_data_out;
    logic                        mem_read_ready;
    logic                        mem_write_ready;
    logic                        mem_invalid_read;
    logic                        mem_invalid_write;

    modport slave (
        input  cl_req, cl_we, cl_addr, cl_wdata,
        output cl_ack, cl_rdata, cl_err,
        output mem_read, mem_write, mem_read_addr, mem_write_addr, mem_data_in,
        input  mem_data_out, mem_read_ready, mem_write_ready,
        input  mem_invalid_read, mem_invalid_write
    );

    modport master (
        output cl_req, cl_we, cl_addr, cl_wdata,
        input  cl_ack, cl_rdata, cl_err,
        input  mem_read, mem_write, mem_read_addr, mem_write_addr, mem_data_in,
        output mem_data_out, mem_read_ready, mem_write_ready,
        output mem_invalid_read, mem_invalid_write
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter serialising single-word client requests onto one sram,
// with per-transaction error reporting and a stall watchdog.
module sram_arbiter #(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t               state, state_d;
    logic [IDX_W-1:0]     rr_ptr, rr_ptr_d, grant, grant_d, pick;
    logic                 found;
    int unsigned          idx;
    logic                 we, we_d;
    logic [TMR_W-1:0]     timer, timer_d;
    logic                 err_latch, err_latch_d;
    logic [N_CLIENTS-1:0] ack_q, ack_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic                 strobe, sel_ready, sel_invalid, timed_out;

    assign strobe      = rd_q | wr_q;
    assign sel_ready   = we ? bus.mem_write_ready : bus.mem_read_ready;
    assign sel_invalid = we ? bus.mem_invalid_write : bus.mem_invalid_read;
    assign timed_out   = (timer >= TMR_W'(TIMEOUT - 1));

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < N_CLIENTS; k++) begin
            idx = (32'(rr_ptr) + k) % N_CLIENTS;
            if (!found && bus.cl_req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant     <= '0;
            we        <= 1'b0;
            timer     <= '0;
            err_latch <= 1'b0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            grant     <= grant_d;
            we        <= we_d;
            timer     <= timer_d;
            err_latch <= err_latch_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (found) state_d = ISSUE;
            ISSUE:   if (strobe) state_d = WAIT;
                     else if (timed_out) state_d = ACK;
            WAIT:    if (sel_ready || timed_out) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered, so ready is sampled one cycle ahead: the cycle a
    // strobe is high is the ISSUE cycle the sram sees it in.
    always_comb begin
        grant_d     = grant;
        we_d        = we;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        timer_d     = timer;
        err_latch_d = err_latch;
        rr_ptr_d    = rr_ptr;
        rdata_d     = rdata_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        ack_d       = '0;
        err_d       = 1'b0;
        unique case (state)
            IDLE: if (found) begin
                grant_d     = pick;
                we_d        = bus.cl_we[pick];
                addr_d      = bus.cl_addr[32'(pick)*ADDR_W +: ADDR_W];
                wdata_d     = bus.cl_wdata[32'(pick)*DATA_W +: DATA_W];
                timer_d     = '0;
                err_latch_d = 1'b0;
                rd_d        = ~bus.cl_we[pick] & bus.mem_read_ready;
                wr_d        = bus.cl_we[pick] & bus.mem_write_ready;
            end
            ISSUE: begin
                timer_d = timer + 1'b1;
                if (!strobe) begin
                    if (timed_out) begin
                        err_latch_d = 1'b1;
                    end else begin
                        rd_d = ~we & sel_ready;
                        wr_d = we & sel_ready;
                    end
                end
            end
            WAIT: begin
                timer_d     = timer + 1'b1;
                err_latch_d = err_latch | sel_invalid;
                if (sel_ready) begin
                    if (!we) rdata_d = bus.mem_data_out;
                end else if (timed_out) begin
                    err_latch_d = 1'b1;
                end
            end
            ACK: rr_ptr_d = (grant == IDX_W'(N_CLIENTS - 1)) ? '0 : grant + 1'b1;
            default: ;
        endcase
        if (state_d == ACK) begin
            ack_d[grant] = 1'b1;
            err_d        = err_latch_d;
        end
    end

    assign bus.cl_ack         = ack_q;
    assign bus.cl_err         = err_q;
    assign bus.cl_rdata       = rdata_q;
    assign bus.mem_read       = rd_q;
    assign bus.mem_write      = wr_q;
    assign bus.mem_read_addr  = addr_q;
    assign bus.mem_write_addr = addr_q;
    assign bus.mem_data_in    = wdata_q;
endmodule
